// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the RV32I pipeline: dmem ready/valid requests, lane alignment, load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned/UNDEF memory ops fault instead of being force-aligned.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_size,
  input  logic [31:0]           ex_addr,
  input  logic [31:0]           ex_wdata,
  input  logic [31:0]           ex_result,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_reg_write,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata,
  output logic                  misaligned,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data
);

  typedef enum logic [2:0] {
    SIZE_UNDEF  = 3'd0,
    SIZE_BYTE_S = 3'd1,
    SIZE_BYTE_U = 3'd2,
    SIZE_HALF_S = 3'd3,
    SIZE_HALF_U = 3'd4,
    SIZE_WORD   = 3'd5
  } data_size_e;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e      state;
  logic        mem_op;
  logic        is_byte, is_half, is_signed;
  logic        size_bad, addr_bad, fault;
  logic        complete, stall_c;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, load_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    size_bad  = 1'b0;
    addr_bad  = 1'b0;
    case (ex_size)
      SIZE_BYTE_S: begin is_byte = 1'b1; is_signed = 1'b1; end
      SIZE_BYTE_U: is_byte = 1'b1;
      SIZE_HALF_S: begin is_half = 1'b1; is_signed = 1'b1; addr_bad = ex_addr[0]; end
      SIZE_HALF_U: begin is_half = 1'b1; addr_bad = ex_addr[0]; end
      SIZE_WORD:   addr_bad = |ex_addr[1:0];
      default:     size_bad = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault = mem_op & (size_bad | addr_bad);
`else
  // Without trapping, lane selection ignores the low address bits and UNDEF falls through as WORD.
  logic unused_fault;
  assign fault        = 1'b0;
  assign unused_fault = size_bad ^ addr_bad;
`endif

  logic unused_addr;
  assign unused_addr = ^ex_addr[31:ADDR_WIDTH+2];

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = ex_wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << ex_addr[1:0];
      wdata_next = {4{ex_wdata[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << {ex_addr[1], 1'b0};
      wdata_next = {2{ex_wdata[15:0]}};
    end
  end

  assign sel_byte = 8'(dmem_rdata >> {ex_addr[1:0], 3'b000});
  assign sel_half = ex_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_data = dmem_rdata;
    if (is_byte)      load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
    else if (is_half) load_data = {{16{is_signed & sel_half[15]}}, sel_half};
  end

  always_comb begin
    complete = 1'b0;
    stall_c  = 1'b0;
    case (state)
      S_IDLE: stall_c = mem_op & ~fault;
      S_REQ: begin
        complete = dmem_ready & (dmem_we | dmem_rvalid);
        stall_c  = ~complete;
      end
      S_RESP: begin
        complete = dmem_rvalid;
        stall_c  = ~complete;
      end
      default: ;
    endcase
  end

  assign stall = stall_c & ~rst;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op && !fault) begin
            state      <= S_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= ex_addr[ADDR_WIDTH+1:2];
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            state    <= (dmem_we || dmem_rvalid) ? S_IDLE : S_RESP;
          end
        end
        S_RESP: begin
          if (dmem_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (stall_c) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end else begin
        wb_valid     <= ex_valid;
        wb_rd        <= ex_rd;
        wb_data      <= (complete && !dmem_we) ? load_data : ex_result;
        // Stores and trapped accesses never write rd.
        wb_reg_write <= ex_valid & ex_reg_write & ~(mem_op & (ex_mem_write | fault));
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= ~stall_c & fault;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage of the five-stage RV32I pipeline. Sits between the EX/MEM register and writeback. Issues load and store requests to data memory over a ready/valid handshake. Aligns store data and byte enables by `data_size_e`, and sign- or zero-extends load data. Stalls upstream while an access is outstanding, then presents a registered writeback bundle.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: data-memory word-address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: EX/MEM slot holds a valid instruction.
- `ex_mem_read` in 1: instruction is a load.
- `ex_mem_write` in 1: instruction is a store.
- `ex_size` in 3: `data_size_e` (UNDEF, BYTE_S, BYTE_U, HALF_S, HALF_U, WORD).
- `ex_addr` in 32: byte address (ALU result).
- `ex_wdata` in 32: store data (rs2, already forwarded).
- `ex_result` in 32: ALU result; passed through for non-memory instructions.
- `ex_rd` in 5: destination register.
- `ex_reg_write` in 1: instruction writes `rd`.
- `stall` out 1: hold the EX/MEM register and all earlier stages.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out ADDR_WIDTH: word address, equal to `ex_addr[ADDR_WIDTH+1:2]`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-aligned store data.
- `dmem_ready` in 1: memory accepts the request this cycle.
- `dmem_rvalid` in 1: load data valid.
- `dmem_rdata` in 32: load word.
- `misaligned` out 1: one-cycle fault pulse.
- `wb_valid`, `wb_reg_write` out 1: registered writeback valid and write-enable.
- `wb_rd` out 5: registered destination register.
- `wb_data` out 32: registered writeback data.

## Operation
- A memory op is `ex_valid & (ex_mem_read | ex_mem_write)`. Assertion of both read and write together is illegal and is treated as a store.
- FSM states:
  - IDLE: a memory op moves to REQ. A non-memory op does not.
  - REQ: `dmem_req` is held until `dmem_ready`.
    - A store completes on `dmem_ready` and returns to IDLE.
    - A load with `dmem_ready & dmem_rvalid` completes and returns to IDLE.
    - A load with `dmem_ready` only moves to RESP.
  - RESP: waits for `dmem_rvalid`, then completes and returns to IDLE.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered. They are loaded on the IDLE→REQ transition and held stable until accept. `dmem_req` drops the cycle after accept.
- Store lanes:
  - Byte: `be = 4'b0001 << addr[1:0]`, data byte replicated ×4.
  - Half: `be = 4'b0011 << {addr[1],1'b0}`, data half replicated ×2.
  - Word: `be = 4'b1111`.
- Load extraction: select the byte at `addr[1:0]` or the half at `addr[1]`. `_S` sizes sign-extend to 32 bits. `_U` sizes zero-extend.
- Misalignment is half with `addr[0]=1` or word with `addr[1:0]≠0`. A memory op with UNDEF size is treated the same way.
- `stall` is combinational:
  - 1 in IDLE when a memory op is presented and does not fault.
  - 1 in REQ/RESP except in the completion cycle.
  - 0 otherwise.
- Writeback register, loaded every edge with `stall=0`:
  - Non-memory op: `ex_result`.
  - Load: extended data.
  - Store: `wb_reg_write=0`.
  - `ex_valid=0`: `wb_valid=0`.
- Writeback register when `stall=1`: `wb_valid` is 0.

## Timing
- Non-memory op: `wb_*` valid 1 cycle after presentation, no stall.
- Store with immediate ready: presented cycle 0 (stall=1), `dmem_req` in cycle 1 (stall=0), `wb_valid` in cycle 2.
- Load latency is 2 + (ready wait cycles) + (rvalid wait cycles after accept).
- All outputs reset to 0: `stall`, `dmem_*`, `misaligned`, `wb_*`. FSM resets to IDLE.
- Reset mid-access abandons the transaction. A `dmem_rvalid` seen in IDLE is ignored.
- `dmem_rdata` is sampled only in the completion cycle. Inputs `ex_*` are held stable by upstream while `stall=1`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned or UNDEF memory op issues no dmem request and does not stall.
  - `misaligned` pulses 1 for one cycle, registered alongside `wb_valid=1`, `wb_reg_write=0`.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misaligned` is tied 0.
  - Half forces `addr[0]=0`, word forces `addr[1:0]=0`, and the access proceeds.
  - UNDEF size is treated as WORD.

## Test plan
- LB at 0x103 with rdata 0x80FF_FF7F, ready and rvalid the same cycle → `wb_data=0xFFFF_FF80`, `wb_valid` 2 cycles after presentation.
- LHU at 0x002 with rdata 0xBEEF_1234, ready after 2 wait cycles, rvalid 3 cycles after accept → `wb_data=0x0000_BEEF`. `stall` is high throughout until the rvalid cycle.
- SB at 0x005, wdata 0x0000_00AB → `dmem_addr=1`, `dmem_be=4'b0010`, `dmem_wdata=0xABAB_ABAB`, `wb_reg_write=0`.
- Back-to-back ADD (result 0x7) then SW to 0x010 → ADD writes back 0x7 with no stall. SW presents `dmem_be=4'b1111`, `dmem_addr=4`.
- LW at 0x006:
  - With `LSU_MISALIGN_TRAP_EN`: no `dmem_req`, `misaligned` pulses 1.
  - Without it: access issues at `dmem_addr=1`.
- `rst` asserted while in RESP, then `dmem_rvalid=1` one cycle after release → FSM is in IDLE, `wb_valid=0`, `stall=0`.
